dev_unshuffler: RTL

- Wide-to-narrow consumer for the reshuffler's wide stream.
- Accepts one SpatPar*DataWidth word per handshake and applies the SpatPar x SpatPar transpose on Elems-bit elements. The transpose is self-inverse, so it undoes a prior reshuffle.
- Serialises the result into SpatPar DataWidth-bit beats over a valid-ready port.
- Sits between the reshuffler output (or a wide memory read port) and a narrow streamer or accelerator lane.

---
 rtl/dev_unshuffler.sv | 113 +++++++++++
 1 files changed

// File: rtl/dev_unshuffler.sv
// Wide-to-narrow unshuffler: transposes a SpatPar x SpatPar tile of Elems-bit elements
// and streams it out as SpatPar DataWidth-bit beats. Define DEV_UNSHUFFLER_LAST_EN for z_last_o.
module dev_unshuffler #(
   parameter int SpatPar   = 8,
   parameter int DataWidth = 64,
   parameter int Elems     = DataWidth / SpatPar
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [SpatPar*DataWidth-1:0] a_i,
   input  logic                         a_valid_i,
   output logic                         a_ready_o,
   output logic [DataWidth-1:0]         z_o,
   output logic                         z_valid_o,
   input  logic                         z_ready_i
`ifdef DEV_UNSHUFFLER_LAST_EN
   ,
   output logic                         z_last_o
`endif
);

   localparam int              CntW    = (SpatPar > 1) ? $clog2(SpatPar) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SpatPar - 1);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StSend = 1'b1;

   if (Elems * SpatPar != DataWidth) begin : g_bad_elems
      $error("dev_unshuffler: Elems*SpatPar must equal DataWidth");
   end

   logic [0:0]                          state_q, state_d;
   logic [CntW-1:0]                     cnt_q, cnt_d;
   logic [SpatPar-1:0][DataWidth-1:0]   buf_q, buf_d;
   logic [SpatPar*SpatPar-1:0][Elems-1:0] trans;
   logic [DataWidth-1:0]                beat;
   logic                                send, is_last, z_hs;

   // Buffer element (i,j) takes input element (j,i).
   for (genvar i = 0; i < SpatPar; i++) begin : g_row
      for (genvar j = 0; j < SpatPar; j++) begin : g_col
         assign trans[i*SpatPar+j] = a_i[(j*SpatPar+i)*Elems +: Elems];
      end
   end

   if (SpatPar == 1) begin : g_one_beat
      assign beat = buf_q[0];
   end else begin : g_many_beats
      assign beat = buf_q[cnt_q];
   end

   assign send    = (state_q == StSend);
   assign is_last = (cnt_q == CntLast);

   // Outputs are gated by rst_i so the port is quiet during the reset cycle itself.
   assign z_valid_o = !rst_i && send;
   assign z_o       = z_valid_o ? beat : '0;
   assign a_ready_o = !rst_i && (!send || (is_last && z_ready_i));
   assign z_hs      = z_valid_o && z_ready_i;

`ifdef DEV_UNSHUFFLER_LAST_EN
   assign z_last_o = z_valid_o && is_last;
`endif

   // NOTE: every _d gets a default before the case, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      case (state_q)
         StIdle: begin
            if (a_valid_i) begin
               buf_d   = trans;
               cnt_d   = '0;
               state_d = StSend;
            end
         end
         StSend: begin
            if (z_hs) begin
               if (!is_last) begin
                  cnt_d = cnt_q + CntW'(1);
               end else if (a_valid_i) begin
                  buf_d = trans;
                  cnt_d = '0;
               end else begin
                  buf_d   = '0;
                  cnt_d   = '0;
                  state_d = StIdle;
               end
            end
         end
         default: begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   // NOTE: the data buffer is reset too, so a mid-word reset drops the remaining beats.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

endmodule
